hetic_nest_ctrl: RTL and testbench

//  Sequences interrupt delivery from the HETIC arbiter to the core and tracks preemption nesting.

---
 rtl/hetic_nest_ctrl_if.sv | 42 ++++
 rtl/hetic_nest_ctrl.sv | 140 ++++++++++++++
 tb/tb_hetic_nest_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hetic_nest_ctrl_if.sv
// Interface between the HETIC arbiter, the nesting controller and the core interrupt port.
// The slave side is the controller; the master side drives arbiter/core inputs and observes results.
interface hetic_nest_ctrl_if #(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32,
  parameter int StackDepth = 8
);
  localparam int IrqWidth   = $clog2(NrIrqLines);
  localparam int PrioWidth  = $clog2(NrIrqPrios);
  localparam int DepthWidth = $clog2(StackDepth + 1);

  logic                  arb_valid_i;
  logic [IrqWidth-1:0]   arb_id_i;
  logic [PrioWidth-1:0]  arb_level_i;
  logic                  arb_nest_i;
  logic                  arb_heti_i;
  logic                  core_irq_o;
  logic [IrqWidth-1:0]   core_irq_id_o;
  logic [PrioWidth-1:0]  core_irq_level_o;
  logic                  core_irq_heti_o;
  logic                  core_take_i;
  logic                  core_mret_i;
  logic                  hetic_ack_o;
  logic [IrqWidth-1:0]   hetic_ack_id_o;
  logic [PrioWidth-1:0]  cur_level_o;
  logic [DepthWidth-1:0] depth_o;
  logic                  underflow_o;

  modport master (
    output arb_valid_i, arb_id_i, arb_level_i, arb_nest_i, arb_heti_i,
    output core_take_i, core_mret_i,
    input  core_irq_o, core_irq_id_o, core_irq_level_o, core_irq_heti_o,
    input  hetic_ack_o, hetic_ack_id_o, cur_level_o, depth_o, underflow_o
  );

  modport slave (
    input  arb_valid_i, arb_id_i, arb_level_i, arb_nest_i, arb_heti_i,
    input  core_take_i, core_mret_i,
    output core_irq_o, core_irq_id_o, core_irq_level_o, core_irq_heti_o,
    output hetic_ack_o, hetic_ack_id_o, cur_level_o, depth_o, underflow_o
  );
endinterface

// File: rtl/hetic_nest_ctrl.sv
// Offers the HETIC arbiter winner to the core when it may preempt the running level,
// acks the taken line back to the HETIC and keeps the preemption nesting stack.
module hetic_nest_ctrl #(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32,
  parameter int StackDepth = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  hetic_nest_ctrl_if.slave bus
);
  localparam int IrqWidth   = $clog2(NrIrqLines);
  localparam int PrioWidth  = $clog2(NrIrqPrios);
  localparam int DepthWidth = $clog2(StackDepth + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0]            r_state;
  logic [PrioWidth-1:0]  r_stkLevel [StackDepth];
  logic [StackDepth-1:0] r_stkNest;
  logic [DepthWidth-1:0] r_depth;
  logic                  r_underflow;
  logic                  r_offer;
  logic [IrqWidth-1:0]   r_offId;
  logic [PrioWidth-1:0]  r_offLevel;
  logic                  r_offNest;
  logic                  r_offHeti;
  logic                  r_ack;
  logic [IrqWidth-1:0]   r_ackId;

  logic [PrioWidth-1:0]  w_topLevel;
  logic                  w_topNest;
  logic                  w_eligible;
  logic                  w_take;
  logic                  w_pop;
  logic [DepthWidth-1:0] w_baseDepth;

  always_comb begin
    w_topLevel = '0;
    w_topNest  = 1'b0;
    for (int i = 0; i < StackDepth; i++) begin
      if (r_depth == DepthWidth'(i + 1)) begin
        w_topLevel = r_stkLevel[i];
        w_topNest  = r_stkNest[i];
      end
    end
  end

  // Equal level never preempts; a non-nestable handler blocks everything until it returns.
  assign w_eligible = bus.arb_valid_i && (bus.arb_level_i != '0) &&
                      (r_depth < DepthWidth'(StackDepth)) &&
                      ((r_depth == '0) || (w_topNest && (bus.arb_level_i > w_topLevel)));

  assign w_take      = (r_state == ST_OFFER) && bus.core_take_i;
  assign w_pop       = bus.core_mret_i && (r_depth != '0);
  assign w_baseDepth = w_pop ? (r_depth - DepthWidth'(1)) : r_depth;

  // A same-cycle return and take pops first, so the new entry replaces the old top.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_depth     <= '0;
      r_underflow <= 1'b0;
      r_stkNest   <= '0;
      for (int i = 0; i < StackDepth; i++) r_stkLevel[i] <= '0;
    end else begin
      if (bus.core_mret_i && (r_depth == '0)) r_underflow <= 1'b1;
      if (w_take && (w_baseDepth < DepthWidth'(StackDepth))) begin
        for (int i = 0; i < StackDepth; i++) begin
          if (w_baseDepth == DepthWidth'(i)) begin
            r_stkLevel[i] <= r_offLevel;
            r_stkNest[i]  <= r_offNest;
          end
        end
        r_depth <= w_baseDepth + DepthWidth'(1);
      end else begin
        r_depth <= w_baseDepth;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_offer    <= 1'b0;
      r_offId    <= '0;
      r_offLevel <= '0;
      r_offNest  <= 1'b0;
      r_offHeti  <= 1'b0;
      r_ack      <= 1'b0;
      r_ackId    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (w_eligible) begin
            r_state    <= ST_OFFER;
            r_offer    <= 1'b1;
            r_offId    <= bus.arb_id_i;
            r_offLevel <= bus.arb_level_i;
            r_offNest  <= bus.arb_nest_i;
            r_offHeti  <= bus.arb_heti_i;
          end
        end
        ST_OFFER: begin
          if (bus.core_take_i) begin
            r_state <= ST_ACK;
            r_offer <= 1'b0;
            r_ack   <= 1'b1;
            r_ackId <= r_offId;
          end else if (!w_eligible || (bus.arb_id_i != r_offId)) begin
            r_state <= ST_IDLE;
            r_offer <= 1'b0;
          end
        end
        // One idle cycle after the ack gives the HETIC time to clear the pending bit.
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_offer <= 1'b0;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_irq_o       = r_offer;
  assign bus.core_irq_id_o    = r_offId;
  assign bus.core_irq_level_o = r_offLevel;
  assign bus.core_irq_heti_o  = r_offHeti;
  assign bus.hetic_ack_o      = r_ack;
  assign bus.hetic_ack_id_o   = r_ackId;
  assign bus.cur_level_o      = w_topLevel;
  assign bus.depth_o          = r_depth;
  assign bus.underflow_o      = r_underflow;
endmodule

// File: tb/tb_hetic_nest_ctrl.sv
// Directed plus randomized bench for hetic_nest_ctrl, checked against a queue-based
// model of offer/ack/nesting behaviour.
module tb_hetic_nest_ctrl;
  localparam int NrIrqLines = 64;
  localparam int NrIrqPrios = 32;
  localparam int StackDepth = 8;

  typedef struct {
    logic [4:0] level;
    logic       nest;
  } entry_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  entry_t     mStack[$];
  logic       mOffering;
  logic [5:0] mOffId;
  logic [4:0] mOffLevel;
  logic       mOffNest;
  logic       mOffHeti;
  logic       mAck;
  logic [5:0] mAckId;
  logic       mUnderflow;

  hetic_nest_ctrl_if #(.NrIrqLines(NrIrqLines), .NrIrqPrios(NrIrqPrios), .StackDepth(StackDepth)) bus ();

  hetic_nest_ctrl #(.NrIrqLines(NrIrqLines), .NrIrqPrios(NrIrqPrios), .StackDepth(StackDepth)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expectEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mStack.delete();
    mOffering  = 1'b0;
    mOffId     = '0;
    mOffLevel  = '0;
    mOffNest   = 1'b0;
    mOffHeti   = 1'b0;
    mAck       = 1'b0;
    mAckId     = '0;
    mUnderflow = 1'b0;
  endtask

  // Model: eligibility from the stack as it stood before this edge, then return/take, then offer state.
  task automatic modelStep(input logic v, input logic [5:0] id, input logic [4:0] lvl,
                           input logic n, input logic h, input logic tk, input logic mr);
    int     sz;
    logic   elig;
    logic   takeEff;
    entry_t e;
    sz   = mStack.size();
    elig = v && (lvl != 0) && (sz < StackDepth) &&
           ((sz == 0) || (mStack[sz-1].nest && (lvl > mStack[sz-1].level)));
    takeEff = mOffering && tk;
    if (mr) begin
      if (sz > 0) void'(mStack.pop_back());
      else mUnderflow = 1'b1;
    end
    if (takeEff) begin
      e.level = mOffLevel;
      e.nest  = mOffNest;
      mStack.push_back(e);
    end
    if (mAck) begin
      mAck = 1'b0;
    end else if (mOffering) begin
      if (tk) begin
        mAck      = 1'b1;
        mAckId    = mOffId;
        mOffering = 1'b0;
      end else if (!elig || (id != mOffId)) begin
        mOffering = 1'b0;
      end
    end else if (elig) begin
      mOffering = 1'b1;
      mOffId    = id;
      mOffLevel = lvl;
      mOffNest  = n;
      mOffHeti  = h;
    end
  endtask

  task automatic checkOutput();
    int sz;
    sz = mStack.size();
    expectEq("core_irq", bus.core_irq_o, mOffering);
    if (mOffering) begin
      expectEq("core_irq_id", bus.core_irq_id_o, mOffId);
      expectEq("core_irq_level", bus.core_irq_level_o, mOffLevel);
      expectEq("core_irq_heti", bus.core_irq_heti_o, mOffHeti);
    end
    expectEq("hetic_ack", bus.hetic_ack_o, mAck);
    if (mAck) expectEq("hetic_ack_id", bus.hetic_ack_id_o, mAckId);
    expectEq("depth", bus.depth_o, sz);
    expectEq("cur_level", bus.cur_level_o, (sz == 0) ? 0 : mStack[sz-1].level);
    expectEq("underflow", bus.underflow_o, mUnderflow);
  endtask

  task automatic applyStimulus(input logic v, input int id, input int lvl, input logic n,
                               input logic h, input logic tk, input logic mr);
    bus.arb_valid_i = v;
    bus.arb_id_i    = 6'(id);
    bus.arb_level_i = 5'(lvl);
    bus.arb_nest_i  = n;
    bus.arb_heti_i  = h;
    bus.core_take_i = tk;
    bus.core_mret_i = mr;
    modelStep(v, 6'(id), 5'(lvl), n, h, tk, mr);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    rst = 1'b1;
    bus.arb_valid_i = 1'b0;
    bus.arb_id_i    = '0;
    bus.arb_level_i = '0;
    bus.arb_nest_i  = 1'b0;
    bus.arb_heti_i  = 1'b0;
    bus.core_take_i = 1'b0;
    bus.core_mret_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput();
  endtask

  initial begin
    logic       rv;
    logic       rn;
    logic       rh;
    int         rid;
    int         rlvl;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    resetDut();

    // Basic offer, take and ack pulse.
    applyStimulus(1, 5, 3, 1, 1, 0, 0);
    expectEq("t1_offer", bus.core_irq_o, 1);
    expectEq("t1_offer_id", bus.core_irq_id_o, 5);
    applyStimulus(1, 5, 3, 1, 1, 1, 0);
    expectEq("t1_ack", bus.hetic_ack_o, 1);
    expectEq("t1_ack_id", bus.hetic_ack_id_o, 5);
    expectEq("t1_depth", bus.depth_o, 1);
    expectEq("t1_cur", bus.cur_level_o, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expectEq("t1_ack_pulse", bus.hetic_ack_o, 0);

    // Nested preemption and return.
    applyStimulus(1, 9, 7, 0, 0, 0, 0);
    applyStimulus(1, 9, 7, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    expectEq("t2_depth", bus.depth_o, 2);
    expectEq("t2_cur", bus.cur_level_o, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    expectEq("t2_pop_cur", bus.cur_level_o, 3);

    // Equal level is blocked until the running handler returns.
    applyStimulus(1, 11, 3, 0, 0, 0, 0);
    applyStimulus(1, 11, 3, 0, 0, 0, 0);
    expectEq("t3_blocked", bus.core_irq_o, 0);
    applyStimulus(1, 11, 3, 0, 0, 0, 1);
    applyStimulus(1, 11, 3, 0, 0, 0, 0);
    expectEq("t3_offer_after_mret", bus.core_irq_o, 1);
    applyStimulus(1, 11, 3, 0, 0, 1, 0);
    applyStimulus(1, 12, 9, 1, 0, 0, 0);
    applyStimulus(1, 12, 9, 1, 0, 0, 0);
    expectEq("t3_nonest_blocked", bus.core_irq_o, 0);

    // Retract on winner change, then reoffer the new winner.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 5, 4, 1, 0, 0, 0);
    applyStimulus(1, 7, 6, 1, 0, 0, 0);
    expectEq("t4_retract", bus.core_irq_o, 0);
    applyStimulus(1, 7, 6, 1, 0, 0, 0);
    expectEq("t4_reoffer_id", bus.core_irq_id_o, 7);

    // Fill the stack, confirm no further offer, then drain past empty.
    resetDut();
    for (int i = 1; i <= StackDepth; i++) begin
      applyStimulus(1, i, i, 1, 0, 0, 0);
      applyStimulus(1, i, i, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
    expectEq("t5_full_depth", bus.depth_o, StackDepth);
    applyStimulus(1, 20, 9, 1, 0, 0, 0);
    applyStimulus(1, 20, 9, 1, 0, 0, 0);
    expectEq("t5_full_no_offer", bus.core_irq_o, 0);
    for (int i = 0; i <= StackDepth; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    expectEq("t5_underflow", bus.underflow_o, 1);

    // Asynchronous reset while an offer is outstanding.
    applyStimulus(1, 5, 3, 1, 0, 0, 0);
    applyStimulus(1, 5, 3, 1, 0, 1, 0);
    applyStimulus(1, 6, 8, 1, 0, 0, 0);
    applyStimulus(1, 6, 8, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    expectEq("t6_async_irq", bus.core_irq_o, 0);
    expectEq("t6_async_ack", bus.hetic_ack_o, 0);
    expectEq("t6_async_depth", bus.depth_o, 0);
    expectEq("t6_async_underflow", bus.underflow_o, 0);
    resetDut();

    // Randomized traffic with a slowly changing arbiter winner.
    rv = 1'b1; rid = 1; rlvl = 2; rn = 1'b1; rh = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        rv   = ($urandom_range(0, 9) < 8);
        rid  = $urandom_range(0, 3);
        rlvl = $urandom_range(0, 12);
        rn   = ($urandom_range(0, 3) != 0);
        rh   = 1'($urandom_range(0, 1));
      end
      applyStimulus(rv, rid, rlvl, rn, rh, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
